fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side master for synchronous_fifo: drives rd_en, captures data_out one cycle later, re-presents words on a valid/ready output stream.
- Internal skid buffer absorbs FIFO read latency and downstream backpressure without losing or duplicating words.
- Sits between the FIFO read port and any ready-throttled consumer.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and output stream.
- BUF_DEPTH, 2, skid buffer entries; power of two, >= 2.
- COUNT_WIDTH, 16, width of delivered-word counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  1  permits new FIFO reads; buffered words still drain when low.
- fifo_empty  input  1  empty flag from FIFO.
- fifo_rdata  input  DATA_WIDTH  FIFO data_out; valid the cycle after the edge that sampled fifo_rd_en=1.
- fifo_rd_en  output  1  read request to FIFO (combinational).
- m_valid  output  1  output word available.
- m_ready  input  1  consumer accepts word.
- m_data  output  DATA_WIDTH  output word (buffer head).
- word_count  output  COUNT_WIDTH  total words accepted downstream.
- idle  output  1  buffer empty and no read in flight.

Behaviour:
- Reset values (clk edge with reset=1): m_valid=0, m_data=0, word_count=0, idle=1, occupancy=0, inflight=0. fifo_rd_en forced 0 while reset=1.
- State: occupancy (0..BUF_DEPTH), inflight flag (1 bit, set when fifo_rd_en sampled 1), circular buffer with rd_ptr/wr_ptr wrapping modulo BUF_DEPTH.
- pop = m_valid && m_ready.
- fifo_rd_en = !reset && enable && !fifo_empty && (occupancy + inflight - pop) < BUF_DEPTH.
- Capture: if inflight=1, fifo_rdata written at wr_ptr at that edge; inflight then takes the current fifo_rd_en value.
- Latency: FIFO non-empty, buffer empty, enable=1 in cycle N -> fifo_rd_en=1 in N, capture at end of N+1, m_valid=1 in N+2 with that word.
- Throughput: with m_ready held 1, one word per cycle sustained (steady state occupancy=1, inflight=1).
- Simultaneous capture and pop in one cycle: both happen; occupancy unchanged.
- Output protocol: once m_valid=1, m_valid and m_data are held stable until pop. m_valid = (occupancy != 0).
- Buffer can never overflow; a capture into a full buffer is a design error (bench asserts).
- FIFO ordering preserved exactly; no drop, no duplicate.
- enable falling: no new fifo_rd_en; an in-flight read still completes and is captured; buffered words still delivered.
- fifo_empty=1: fifo_rd_en=0; never reads an empty FIFO.
- word_count increments by 1 per pop, wraps 2^COUNT_WIDTH-1 -> 0.
- idle = (occupancy==0) && !inflight.
- Reset mid-operation: buffered and in-flight words discarded; fifo_rdata in the cycle after reset is not captured; outputs take reset values at that edge.

Test Plan:
- After reset, write 0x11,0x22,0x33 into FIFO, enable=1, m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles; first m_valid 2 cycles after first fifo_rd_en; word_count=3; idle=1 at the end.
- FIFO holds 32 words, m_ready=1 -> 32 consecutive pops, values match write order, word_count=32, fifo_rd_en drops the cycle fifo_empty rises.
- 8 words queued, m_ready toggles 1,0,0,1 repeating -> m_data stable while m_ready=0, occupancy never exceeds 2, all 8 words in order.
- enable=0 with 5 words queued -> fifo_rd_en stays 0, m_valid=0, idle=1; enable=1 -> words 1..5 delivered.
- Reset asserted one cycle after fifo_rd_en with buffer holding 2 words -> next cycle m_valid=0, word_count=0, idle=1; in-flight word not delivered.
- COUNT_WIDTH=4, 17 words passed through -> word_count reads 1 after wrap.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO: issues reads, absorbs the one-cycle
// read latency in a small skid buffer and re-presents words on a valid/ready stream.
module fifo_stream_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int BUF_DEPTH   = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_rdata,
    output logic                   fifo_rd_en,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic                   idle
);

    localparam int PTR_WIDTH = $clog2(BUF_DEPTH);
    localparam int OCC_WIDTH = $clog2(BUF_DEPTH + 1);
    localparam logic [OCC_WIDTH:0] DEPTH_LIMIT = (OCC_WIDTH + 1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [OCC_WIDTH-1:0]  occupancy;
    logic                  inflight;
    logic                  pop;
    logic [OCC_WIDTH:0]    committed;

    // committed counts slots already owed after this edge: stored words plus
    // the word in flight, minus the word leaving now. It is also next occupancy.
    always_comb begin
        pop        = m_valid && m_ready;
        committed  = {1'b0, occupancy} + {{OCC_WIDTH{1'b0}}, inflight}
                   - {{OCC_WIDTH{1'b0}}, pop};
        fifo_rd_en = !reset && enable && !fifo_empty && (committed < DEPTH_LIMIT);
    end

    assign m_valid = (occupancy != '0);
    assign m_data  = mem[rd_ptr];
    assign idle    = (occupancy == '0) && !inflight;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem        <= '{default: '0};
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occupancy  <= '0;
            inflight   <= 1'b0;
            word_count <= '0;
        end else begin
            if (inflight) begin
                mem[wr_ptr] <= fifo_rdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                word_count <= word_count + 1'b1;
            end
            occupancy <= committed[OCC_WIDTH-1:0];
            inflight  <= fifo_rd_en;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: behavioural FIFO source, stream
// scoreboard, table-driven traffic scenarios and hand-written corner sequences.
module tb_fifo_stream_reader;

    localparam int BD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        m_ready;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [15:0] word_count;
    logic        idle;

    logic        fifo_rd_en4;
    logic        m_valid4;
    logic [7:0]  m_data4;
    logic [3:0]  word_count4;
    logic        idle4;

    fifo_stream_reader #(.DATA_WIDTH(8), .BUF_DEPTH(BD), .COUNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .word_count(word_count), .idle(idle)
    );

    // Narrow-counter copy sharing the same stimulus, used to observe wrap.
    fifo_stream_reader #(.DATA_WIDTH(8), .BUF_DEPTH(BD), .COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en4), .m_valid(m_valid4),
        .m_ready(m_ready), .m_data(m_data4), .word_count(word_count4), .idle(idle4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nwords;
        logic [7:0]  first;
        logic [3:0]  ready_pat;
        int          budget;
        logic [15:0] exp_wc;
    } vec_t;

    vec_t        vecs [4];
    logic [7:0]  fifo_q [$];
    logic [7:0]  exp_q  [$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_count;
    int          outstanding;
    logic        held_valid;
    logic [7:0]  held_data;
    logic        rd_pending;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic flush();
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        flush();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input logic [3:0] pat, input int budget, input string name);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            m_ready = pat[c % 4];
            cyc();
            if (exp_q.size() == 0 && idle) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: timed out with %0d words undelivered, required 0", name, exp_q.size());
        end
    endtask

    // Samples the stream on the falling edge and plays the FIFO read port,
    // returning data one cycle after a sampled read request.
    task automatic monitor();
        forever begin
            @(negedge clk);
            rd_pending = fifo_rd_en;
            if (reset) begin
                check("rd_en_in_reset", fifo_rd_en, 0);
                held_valid  = 1'b0;
                outstanding = 0;
                exp_count   = '0;
            end else begin
                if (fifo_empty) check("rd_en_when_empty", fifo_rd_en, 0);
                check("word_count", word_count, exp_count);
                check("word_count_w4", word_count4, exp_count[3:0]);
                if (held_valid) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data", m_data, held_data);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%0h, required no word", m_data);
                    end else begin
                        check("stream_data", m_data, exp_q.pop_front());
                    end
                    exp_count++;
                    outstanding--;
                end
                if (fifo_rd_en) outstanding++;
                check("no_overflow", (outstanding <= BD), 1);
                held_valid = m_valid && !m_ready;
                held_data  = m_data;
            end
            @(posedge clk);
            #1;
            if (rd_pending && fifo_q.size() > 0) begin
                fifo_rdata = fifo_q.pop_front();
                fifo_empty = (fifo_q.size() == 0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; m_ready = 1'b1;
        fifo_empty = 1'b1; fifo_rdata = '0;
        exp_count = '0; outstanding = 0; held_valid = 1'b0; held_data = '0; rd_pending = 1'b0;

        vecs[0] = '{32, 8'h40, 4'b1111, 36, 16'd35};
        vecs[1] = '{8,  8'h80, 4'b1001, 40, 16'd43};
        vecs[2] = '{5,  8'hA0, 4'b0101, 30, 16'd48};
        vecs[3] = '{6,  8'hC0, 4'b0011, 30, 16'd54};

        fork
            monitor();
        join_none

        // Reset values, with a non-empty FIFO and enable high during reset.
        repeat (3) cyc();
        push_word(8'h5A);
        @(negedge clk);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_wc", word_count, 0);
        check("rst_idle", idle, 1);
        cyc();
        reset = 1'b0;
        wait_drain(4'b1111, 10, "first_word");
        check("first_wc", word_count, 1);

        reset_dut();
        @(negedge clk);
        check("rerst_wc", word_count, 0);
        check("rerst_idle", idle, 1);

        // Read latency: request in N, m_valid in N+2, then one word per cycle.
        cyc();
        enable = 1'b0; m_ready = 1'b1;
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        cyc();
        enable = 1'b1;
        @(negedge clk);
        check("lat_rd_en", fifo_rd_en, 1);
        check("lat_valid_n", m_valid, 0);
        @(negedge clk);
        check("lat_valid_n1", m_valid, 0);
        @(negedge clk);
        check("lat_valid_n2", m_valid, 1);
        check("lat_data0", m_data, 8'h11);
        @(negedge clk);
        check("lat_data1", m_data, 8'h22);
        @(negedge clk);
        check("lat_data2", m_data, 8'h33);
        wait_drain(4'b1111, 10, "latency");
        check("lat_wc", word_count, 3);
        check("lat_idle", idle, 1);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < vecs[v].nwords; i++) push_word(vecs[v].first + 8'(i));
            wait_drain(vecs[v].ready_pat, vecs[v].budget, "table");
            check("table_wc", word_count, vecs[v].exp_wc);
            check("table_idle", idle, 1);
            check("table_valid", m_valid, 0);
        end

        // enable low: no reads while words wait in the FIFO.
        enable = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_word(8'hE1 + 8'(i));
        repeat (6) begin
            cyc();
            check("dis_rd_en", fifo_rd_en, 0);
            check("dis_valid", m_valid, 0);
            check("dis_idle", idle, 1);
        end
        enable = 1'b1;
        wait_drain(4'b1111, 20, "enable");
        check("en_wc", word_count, 59);

        // Reset with a buffered word and a read in flight.
        m_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'hB1 + 8'(i));
        cyc();
        cyc();
        reset = 1'b1;
        flush();
        @(negedge clk);
        check("mid_valid_before", m_valid, 1);
        cyc();
        reset = 1'b0; m_ready = 1'b1;
        check("mid_valid", m_valid, 0);
        check("mid_data", m_data, 0);
        check("mid_wc", word_count, 0);
        check("mid_idle", idle, 1);
        repeat (4) begin
            cyc();
            check("mid_no_word", m_valid, 0);
        end

        // 17 words through a 4-bit counter: wraps to 1.
        reset_dut();
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_word(8'h01 + 8'(i));
        wait_drain(4'b1111, 30, "wrap");
        check("wrap_wc16", word_count, 17);
        check("wrap_wc4", word_count4, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
